// File: rtl/au_addsub_issue.sv
// au_addsub_issue: issue/retire stage for the 32-bit CLA add/sub unit.
// Queues ops in a small FIFO, sequences one op at a time through the external
// adder (EXEC -> CAPT -> OUT), computes signed overflow and returns a tagged
// result over a valid/ready handshake.
// Optional feature macro: AU_SAT_EN -- saturate out_s on signed overflow.
module au_addsub_issue #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic             add_ctrl,
  output logic             add_en,
  input  logic [W-1:0]     add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_s,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = 2 * W + 1 + TAG_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_d_c;
  logic [ENT_W-1:0]   head_c;

  logic               push_c;
  logic               pop_c;
  logic               cap_cout_c;
  logic               load_out_c;

  logic [TAG_W-1:0]   tag_r;
  logic               cout_r;

  logic [W-1:0]       b_eff_c;
  logic               ovf_c;
  logic [W-1:0]       res_s_c;

  assign push_c = in_valid & in_ready;
  assign head_c = mem[rd_ptr];

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_d_c = count;
    case ({push_c, pop_c})
      2'b10:   count_d_c = count + CNT_W'(1);
      2'b01:   count_d_c = count - CNT_W'(1);
      default: count_d_c = count;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= {in_a, in_b, in_sub, in_tag};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and datapath strobes
  always_comb begin
    state_d    = state_q;
    pop_c      = 1'b0;
    cap_cout_c = 1'b0;
    load_out_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          pop_c   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cap_cout_c = 1'b1;
        state_d    = S_CAPT;
      end
      S_CAPT: begin
        load_out_c = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (count != '0) begin
            pop_c   = 1'b1;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Signed overflow from the operands actually presented to the adder
  always_comb begin
    b_eff_c = add_ctrl ? ~add_b : add_b;
    ovf_c   = (add_a[W-1] == b_eff_c[W-1]) & (add_s[W-1] != add_a[W-1]);
  end

`ifdef AU_SAT_EN
  // Clamp to the extreme of add_a's sign on overflow
  always_comb begin
    res_s_c = add_s;
    if (ovf_c) begin
      res_s_c = add_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  // Raw wrapping sum
  always_comb begin
    res_s_c = add_s;
  end
`endif

  // FIFO pointers, op registers and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_ctrl  <= 1'b0;
      add_en    <= 1'b0;
      tag_r     <= '0;
      cout_r    <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        {add_a, add_b, add_ctrl, tag_r} <= head_c;
      end
      count     <= count_d_c;
      in_ready  <= (count_d_c < CNT_W'(DEPTH));
      add_en    <= (state_d == S_EXEC);
      out_valid <= (state_d == S_OUT);
      if (cap_cout_c) begin
        cout_r <= add_cout;
      end
      if (load_out_c) begin
        out_s    <= res_s_c;
        out_cout <= cout_r;
        out_ovf  <= ovf_c;
        out_tag  <= tag_r;
      end
    end
  end

endmodule

// File: tb/tb_au_addsub_issue.sv
// Testbench for au_addsub_issue: models the external adder (registered sum,
// combinational carry) and checks results through a scoreboard queue.
module tb_au_addsub_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic [3:0]  in_tag = '0;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_ctrl;
  logic        add_en;
  logic [31:0] add_s = '0;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_s;
  logic        out_cout;
  logic        out_ovf;
  logic [3:0]  out_tag;

`ifdef AU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   en_count = 0;

  au_addsub_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .add_a(add_a), .add_b(add_b), .add_ctrl(add_ctrl), .add_en(add_en),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Adder model: carry is combinational, sum is registered on enable
  logic [32:0] add_full;
  assign add_full = {1'b0, add_a} + {1'b0, (add_ctrl ? ~add_b : add_b)} + 33'(add_ctrl);
  assign add_cout = add_full[32];
  always @(posedge clk) if (add_en === 1'b1) add_s <= add_full[31:0];

  // Count adder enable pulses
  initial forever begin
    @(posedge clk);
    if (add_en === 1'b1) en_count++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one op, wait for acceptance, record its expected result
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [3:0] tag, input logic [31:0] es,
                       input logic ec, input logic eo);
    bit   done = 1'b0;
    exp_t e;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    #1 in_valid = 1'b0;
    check("accept", 32'(done), 32'd1);
    if (done) begin
      e.s = es; e.cout = ec; e.ovf = eo; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compare on handshake, verify outputs hold while stalled
  initial begin
    exp_t e;
    exp_t held;
    bit   held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_s", out_s, e.s);
          check("out_cout", 32'(out_cout), 32'(e.cout));
          check("out_ovf", 32'(out_ovf), 32'(e.ovf));
          check("out_tag", 32'(out_tag), 32'(e.tag));
        end
      end else if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (held_v) begin
          check("stall_s", out_s, held.s);
          check("stall_tag", 32'(out_tag), 32'(held.tag));
          check("stall_flags", {30'd0, out_cout, out_ovf}, {30'd0, held.cout, held.ovf});
        end
        held.s = out_s; held.cout = out_cout; held.ovf = out_ovf; held.tag = out_tag;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int en0;
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_add_en", 32'(add_en), 32'd0);
    check("rst_add_a", add_a, 32'd0);
    check("rst_out_s", out_s, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Simple add with latency and single enable pulse
    out_ready = 1'b1;
    en0 = en_count;
    issue(32'd5, 32'd3, 1'b0, 4'd2, 32'd8, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("lat_e1_en", 32'(add_en), 32'd1);
    check("lat_e1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e2_en", 32'(add_en), 32'd0);
    check("lat_e2_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e3_valid", 32'(out_valid), 32'd1);
    drain();
    check("en_pulses", 32'(en_count - en0), 32'd1);

    // Subtract with and without borrow
    issue(32'd3, 32'd5, 1'b1, 4'd3, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(32'd5, 32'd3, 1'b1, 4'd4, 32'd2, 1'b1, 1'b0);
    // Overflow boundaries
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 4'd5,
          SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'd6,
          SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'd1, 1'b1, 4'd7,
          SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1);
    drain();

    // Backpressure: one op in flight, FIFO full
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(32'(10 * i), 32'(i), 1'b0, 4'(i), 32'(11 * i), 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("full_in_ready_hold", 32'(in_ready), 32'd0);
    check("stalled_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drain();

    // Reset while in CAPT with two ops queued
    en0 = en_count;
    @(negedge clk);
    in_a = 32'd1; in_b = 32'd2; in_sub = 1'b0; in_tag = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_tag = 4'd9;
    @(posedge clk); #1;
    in_tag = 4'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("capt_en_pulses", 32'(en_count - en0), 32'd1);
    check("capt_add_en", 32'(add_en), 32'd0);
    check("capt_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_midrst_in_ready", 32'(in_ready), 32'd1);
    check("post_midrst_valid", 32'(out_valid), 32'd0);
    issue(32'd1, 32'd1, 1'b0, 4'd11, 32'd2, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
